exec_result_arbiter: RTL and testbench

Oldest-first arbiter between the four issue/execute units (two ALU, two divide) and the single memory-stage input. Each cycle it grants at most one valid execution result, choosing the one whose ROB tag is closest to the ROB head. It holds the winner in a one-entry output register with ready/valid backpressure, so a stalled memory stage stalls the execution units through `canGo_o`.

---
 rtl/exec_result_arbiter.sv | 77 +++++++
 tb/tb_exec_result_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/exec_result_arbiter.sv
// exec_result_arbiter: oldest-first grant of one execution result per cycle
// into a single ready/valid output register feeding the memory stage.
module exec_result_arbiter #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int NumUnits   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [ROBsizeLog-1:0]                ROBhead_i,
    input  logic                                 flush_i,
    input  logic [NumUnits-1:0]                  valid_i,
    input  logic [NumUnits-1:0][ROBsizeLog-1:0]  executeTag_i,
    input  logic [NumUnits-1:0][63:0]            executeVal_i,
    input  logic [NumUnits-1:0][9:0]             executeCommands_i,
    input  logic [NumUnits-1:0][3:0]             executeFlags_i,
    output logic [NumUnits-1:0]                  canGo_o,
    input  logic                                 ready_i,
    output logic                                 valid_o,
    output logic [63:0]                          dataToMem_o,
    output logic [ROBsizeLog-1:0]                tagToMem_o,
    output logic [9:0]                           commandsToMem_o,
    output logic [3:0]                           flagsToMem_o
);
    localparam int AW = ROBsizeLog + 1;
    localparam int IW = NumUnits > 1 ? $clog2(NumUnits) : 1;

    logic [NumUnits-1:0][AW-1:0] age;
    logic [AW-1:0]               best_age;
    logic [IW-1:0]               win;
    logic                        any;
    logic                        loadable;

    // Distance from head modulo ROBsize; extra bit keeps tag+ROBsize from wrapping
    always_comb begin
        for (int i = 0; i < NumUnits; i++)
            age[i] = (executeTag_i[i] >= ROBhead_i)
                ? AW'(executeTag_i[i]) - AW'(ROBhead_i)
                : AW'(executeTag_i[i]) + AW'(ROBsize) - AW'(ROBhead_i);
    end

    // Strict less-than lets the lowest index win on equal age
    always_comb begin
        any      = 1'b0;
        win      = '0;
        best_age = '1;
        for (int i = 0; i < NumUnits; i++)
            if (valid_i[i] && (!any || age[i] < best_age)) begin
                any      = 1'b1;
                win      = IW'(i);
                best_age = age[i];
            end
    end

    assign loadable = ~valid_o | ready_i;
    assign canGo_o  = (loadable & any & ~flush_i & ~reset_i) ? (NumUnits'(1) << win) : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_o         <= 1'b0;
            dataToMem_o     <= '0;
            tagToMem_o      <= '0;
            commandsToMem_o <= '0;
            flagsToMem_o    <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (loadable) begin
            valid_o <= any;
            if (any) begin
                dataToMem_o     <= executeVal_i[win];
                tagToMem_o      <= executeTag_i[win];
                commandsToMem_o <= executeCommands_i[win];
                flagsToMem_o    <= executeFlags_i[win];
            end
        end
    end
endmodule

// File: tb/tb_exec_result_arbiter.sv
// tb_exec_result_arbiter: directed steps with a payload scoreboard; each expected
// grant pushes the unit's payload, each loaded output pops and compares it.
module tb_exec_result_arbiter;
    localparam int N = 4;
    localparam int TW = 6;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [63:0]   val;
        logic [9:0]    cmd;
        logic [3:0]    flg;
    } res_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [TW-1:0]        head;
    logic                 flush;
    logic [N-1:0]         vld;
    logic [N-1:0][TW-1:0] tag_in;
    logic [N-1:0][63:0]   val_in;
    logic [N-1:0][9:0]    cmd_in;
    logic [N-1:0][3:0]    flg_in;
    logic [N-1:0]         can_go;
    logic                 ready;
    logic                 vo;
    logic [63:0]          data_o;
    logic [TW-1:0]        tag_o;
    logic [9:0]           cmd_o;
    logic [3:0]           flg_o;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    exec_result_arbiter dut (
        .clk_i(clk), .reset_i(rst), .ROBhead_i(head), .flush_i(flush),
        .valid_i(vld), .executeTag_i(tag_in), .executeVal_i(val_in),
        .executeCommands_i(cmd_in), .executeFlags_i(flg_in), .canGo_o(can_go),
        .ready_i(ready), .valid_o(vo), .dataToMem_o(data_o), .tagToMem_o(tag_o),
        .commandsToMem_o(cmd_o), .flagsToMem_o(flg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Payload derived from the tag so every field differs per result
    task automatic set_unit(input int u, input logic v, input logic [TW-1:0] t);
        vld[u]    = v;
        tag_in[u] = t;
        val_in[u] = {32'hC0DE_0000 + 32'(t), 32'h1234_5678 ^ 32'(t)};
        cmd_in[u] = {t, 4'h5};
        flg_in[u] = t[3:0] ^ 4'hA;
    endtask

    task automatic grant(input string name, input logic [N-1:0] exp, input int u);
        #1;
        chk(name, can_go, exp);
        sb.push_back('{tag: tag_in[u], val: val_in[u], cmd: cmd_in[u], flg: flg_in[u]});
    endtask

    task automatic check_out(input string name);
        res_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, valid_o=%0b", name, vo);
            return;
        end
        e = sb.pop_front();
        chk({name, "_valid"}, vo, 1'b1);
        chk({name, "_tag"}, tag_o, e.tag);
        chk({name, "_data"}, data_o, e.val);
        chk({name, "_cmd"}, cmd_o, e.cmd);
        chk({name, "_flags"}, flg_o, e.flg);
    endtask

    initial begin
        int order[4];
        rst = 1'b1; head = '0; flush = 1'b0; ready = 1'b1;
        vld = '0; tag_in = '0; val_in = '0; cmd_in = '0; flg_in = '0;
        set_unit(0, 1'b1, 6'd1);
        tick();
        #1;
        chk("reset_cango", can_go, 4'b0000);
        chk("reset_valid", vo, 1'b0);
        chk("reset_data", data_o, 64'd0);
        vld = '0;
        rst = 1'b0;
        tick();

        // Oldest-first across the wrap: head 30, ages {4,1,2,31}
        head = 6'd30;
        set_unit(0, 1'b1, 6'd2);
        set_unit(1, 1'b1, 6'd31);
        set_unit(2, 1'b1, 6'd0);
        set_unit(3, 1'b1, 6'd29);
        grant("wrap_g1", 4'b0010, 1);
        tick(); vld[1] = 1'b0; check_out("wrap_o1");
        grant("wrap_g2", 4'b0100, 2);
        tick(); vld[2] = 1'b0; check_out("wrap_o2");
        grant("wrap_g3", 4'b0001, 0);
        tick(); vld[0] = 1'b0; check_out("wrap_o3");
        grant("wrap_g4", 4'b1000, 3);
        tick(); vld[3] = 1'b0; check_out("wrap_o4");
        #1; chk("idle_cango", can_go, 4'b0000);
        tick();
        chk("idle_drain_valid", vo, 1'b0);

        // Backpressure: tag 5 held while ready is low, tag 6 waits
        head = 6'd0;
        set_unit(0, 1'b1, 6'd5);
        grant("bp_g5", 4'b0001, 0);
        tick(); set_unit(0, 1'b1, 6'd6); ready = 1'b0; check_out("bp_o5");
        for (int k = 0; k < 3; k++) begin
            #1; chk("bp_stall_cango", can_go, 4'b0000);
            tick();
            chk("bp_hold_valid", vo, 1'b1);
            chk("bp_hold_tag", tag_o, 6'd5);
        end
        ready = 1'b1;
        grant("bp_g6", 4'b0001, 0);
        tick(); vld[0] = 1'b0; check_out("bp_o6");

        // Streaming with units out of tag order: tags u0=10 u1=8 u2=11 u3=9
        set_unit(0, 1'b1, 6'd10);
        set_unit(1, 1'b1, 6'd8);
        set_unit(2, 1'b1, 6'd11);
        set_unit(3, 1'b1, 6'd9);
        order = '{1, 3, 0, 2};
        for (int k = 0; k < 4; k++) begin
            grant("stream_g", N'(1) << order[k], order[k]);
            tick(); vld[order[k]] = 1'b0; check_out("stream_o");
        end
        #1; chk("stream_end_cango", can_go, 4'b0000);
        tick();
        chk("stream_end_valid", vo, 1'b0);

        // Flush beats a pending grant and clears the held result
        set_unit(2, 1'b1, 6'd12);
        grant("fl_g12", 4'b0100, 2);
        tick(); set_unit(2, 1'b1, 6'd13); flush = 1'b1; check_out("fl_o12");
        #1; chk("fl_cango", can_go, 4'b0000);
        tick(); flush = 1'b0;
        chk("fl_valid", vo, 1'b0);
        grant("fl_g13", 4'b0100, 2);
        tick(); set_unit(2, 1'b1, 6'd14); check_out("fl_o13");

        // Asynchronous reset mid-cycle with a held result and a requester
        #2; rst = 1'b1;
        #1;
        chk("arst_valid", vo, 1'b0);
        chk("arst_data", data_o, 64'd0);
        chk("arst_tag", tag_o, 6'd0);
        chk("arst_cmd", cmd_o, 10'd0);
        chk("arst_flags", flg_o, 4'd0);
        chk("arst_cango", can_go, 4'b0000);
        tick();
        chk("arst_hold_cango", can_go, 4'b0000);
        chk("arst_hold_valid", vo, 1'b0);
        rst = 1'b0;
        grant("post_rst_g", 4'b0100, 2);
        tick(); vld[2] = 1'b0; check_out("post_rst_o");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
